// File: rtl/fetch_if.sv
// Instruction-memory read channel between the fetch stage and the instruction memory.
// The master drives a level request and address; the slave answers with done and data.
interface fetch_if;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_done;

  modport master (output imem_rd, output imem_addr, input imem_data, input imem_done);
  modport slave  (input imem_rd, input imem_addr, output imem_data, output imem_done);
endinterface

// File: rtl/fetch.sv
// Fetch stage: holds the PC, reads instructions over a variable-latency handshake and
// presents a registered instruction / PC+2 pair to decode, with stall, redirect and HALT.
module fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_redirect_en,
  input  logic [15:0] i_redirect_PC,
  fetch_if.master     imem,
  output logic [15:0] o_instruc,
  output logic [15:0] o_seq_PC,
  output logic        o_if_valid,
  output logic        o_halted
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_FLUSH, S_HALTED} state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_instruc;
  logic [15:0] r_seq_pc;
  logic        r_if_valid;
  logic        r_halted;

  state_t      w_state_next;
  logic [15:0] w_pc_next;
  logic [15:0] w_instruc_next;
  logic [15:0] w_seq_pc_next;
  logic        w_if_valid_next;
  logic        w_halted_next;
  logic        w_free;
  logic        w_rd;
  logic [15:0] w_pc_inc;

  // The output register can take a new word when it is empty or being consumed now.
  assign w_free   = !r_if_valid || !i_stall;
  assign w_pc_inc = r_pc + 16'd2;
  assign w_rd     = rst && (r_state == S_FETCH) && w_free;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_instruc  <= NOP_INSTR;
      r_seq_pc   <= 16'h0000;
      r_if_valid <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_instruc  <= w_instruc_next;
      r_seq_pc   <= w_seq_pc_next;
      r_if_valid <= w_if_valid_next;
      r_halted   <= w_halted_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_instruc_next  = r_instruc;
    w_seq_pc_next   = r_seq_pc;
    w_if_valid_next = r_if_valid;
    w_halted_next   = r_halted;

    if (i_redirect_en) begin
      // Redirect wins over everything; any same-cycle memory data is dropped.
      w_pc_next       = i_redirect_PC;
      w_if_valid_next = 1'b0;
      w_instruc_next  = NOP_INSTR;
      w_halted_next   = 1'b0;
      w_state_next    = S_FLUSH;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (!w_free) begin
            w_state_next = S_HOLD;
          end else if (imem.imem_done) begin
            w_instruc_next  = imem.imem_data;
            w_seq_pc_next   = w_pc_inc;
            w_if_valid_next = 1'b1;
            w_pc_next       = w_pc_inc;
            if (imem.imem_data[15:11] == 5'b00000) begin
              w_state_next  = S_HALTED;
              w_halted_next = 1'b1;
            end
          end else if (r_if_valid) begin
            w_if_valid_next = 1'b0;
            w_instruc_next  = NOP_INSTR;
          end
        end
        S_HOLD: begin
          if (!i_stall) begin
            w_if_valid_next = 1'b0;
            w_instruc_next  = NOP_INSTR;
            w_state_next    = S_FETCH;
          end
        end
        S_FLUSH: begin
          w_state_next = S_FETCH;
        end
        S_HALTED: begin
          if (r_if_valid && !i_stall) begin
            w_if_valid_next = 1'b0;
            w_instruc_next  = NOP_INSTR;
          end
        end
        default: begin
          w_state_next = S_FETCH;
        end
      endcase
    end
  end

  assign imem.imem_rd   = w_rd;
  assign imem.imem_addr = r_pc;
  assign o_instruc      = r_instruc;
  assign o_seq_PC       = r_seq_pc;
  assign o_if_valid     = r_if_valid;
  assign o_halted       = r_halted;

endmodule
